ks_adder_pipe: RTL

Parametrised, pipelined Kogge-Stone adder/subtractor for the FFT datapath butterflies. Generalises the fixed 16-bit prefix-stage blocks to any power-of-two width, registers every prefix level, and adds subtract mode, carry-out/overflow flags and a valid/ready handshake with backpressure. It sits between operand fetch and the butterfly output register.

---
 rtl/ks_pkg.sv | 30 +++
 rtl/black_cell.sv | 14 +
 rtl/grey_cell.sv | 11 +
 rtl/ks_prefix_level.sv | 67 ++++++
 rtl/ks_adder_pipe.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/ks_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder: prefix depth, width
// legality and the control bundle that travels with each beat.
package ks_pkg;

   localparam int KS_MIN_WIDTH = 4;
   localparam int KS_MAX_WIDTH = 64;

   typedef struct packed {
      logic valid;
      logic sub;
      logic cin;
   } ks_ctrl_t;

   function automatic int ks_log2(input int w);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < w) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   function automatic bit ks_width_ok(input int w);
      return (w >= KS_MIN_WIDTH) && (w <= KS_MAX_WIDTH) &&
             ((w & (w - 32'sd1)) == 32'sd0);
   endfunction

endpackage

// File: rtl/black_cell.sv
// Prefix black cell: combines two adjacent (generate, propagate) groups.
module black_cell (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   input  logic p_lo,
   output logic g_out,
   output logic p_out
);

   assign g_out = g_hi | (p_hi & g_lo);
   assign p_out = p_hi & p_lo;

endmodule

// File: rtl/grey_cell.sv
// Prefix grey cell: group generate only, for groups already anchored at bit -1.
module grey_cell (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   output logic g_out
);

   assign g_out = g_hi | (p_hi & g_lo);

endmodule

// File: rtl/ks_prefix_level.sv
// One registered Kogge-Stone prefix level; LEVEL k combines bits DIST=2^(k-1)
// apart and folds the carry-in into bit DIST-1.
module ks_prefix_level
   import ks_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LEVEL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             advance,
   input  logic [WIDTH-1:0] g_prev,
   input  logic [WIDTH-1:0] p_prev,
   input  logic [WIDTH-1:0] p_save_prev,
   input  ks_ctrl_t         ctrl_prev,
   output logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] p_save,
   output ks_ctrl_t         ctrl
);

   localparam int DIST = 32'sd1 << (LEVEL - 1);

   logic [WIDTH-1:0] g_nxt_s;
   logic [WIDTH-1:0] p_nxt_s;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= DIST) begin : g_black
         black_cell u_cell (
            .g_hi  (g_prev[i]),
            .p_hi  (p_prev[i]),
            .g_lo  (g_prev[i-DIST]),
            .p_lo  (p_prev[i-DIST]),
            .g_out (g_nxt_s[i]),
            .p_out (p_nxt_s[i])
         );
      end else if (i == DIST - 1) begin : g_grey
         // carry-in acts as the generate of bit -1
         grey_cell u_cell (
            .g_hi  (g_prev[i]),
            .p_hi  (p_prev[i]),
            .g_lo  (ctrl_prev.cin),
            .g_out (g_nxt_s[i])
         );
         assign p_nxt_s[i] = p_prev[i];
      end else begin : g_pass
         assign g_nxt_s[i] = g_prev[i];
         assign p_nxt_s[i] = p_prev[i];
      end
   end

   // level pipeline register, moves only on the global advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g      <= '0;
         p      <= '0;
         p_save <= '0;
         ctrl   <= '0;
      end else if (advance) begin
         g      <= g_nxt_s;
         p      <= p_nxt_s;
         p_save <= p_save_prev;
         ctrl   <= ctrl_prev;
      end
   end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready backpressure:
// pre-processing stage, LOG2W registered prefix levels, registered sum stage.
module ks_adder_pipe
   import ks_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_c0,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf
);

   localparam int LOG2W = ks_log2(WIDTH);

   if (!ks_width_ok(WIDTH)) begin : g_bad_width
      $error("ks_adder_pipe: WIDTH must be a power of two in 4..64");
   end

   logic             advance_s;
   logic [WIDTH-1:0] b_eff_s;
   logic             cin_s;

   logic [WIDTH-1:0] g_pre_r;
   logic [WIDTH-1:0] p_pre_r;
   logic [WIDTH-1:0] p_save_pre_r;
   ks_ctrl_t         ctrl_pre_r;

   logic [WIDTH-1:0] g_lvl_s      [LOG2W+1];
   logic [WIDTH-1:0] p_lvl_s      [LOG2W+1];
   logic [WIDTH-1:0] p_save_lvl_s [LOG2W+1];
   ks_ctrl_t         ctrl_lvl_s   [LOG2W+1];

   logic [WIDTH-1:0] carry_s;
   logic [WIDTH-1:0] sum_s;
   logic             cout_s;
   logic             ovf_s;

   logic             valid_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             ovf_r;

   // whole pipe moves in lockstep; it stalls only when the output slot is held
   assign advance_s = ~valid_r | i_ready;
   assign o_ready   = advance_s;

   // operand B conditioning for subtract
   always_comb begin
      b_eff_s = i_b;
      if (i_sub) begin
         b_eff_s = ~i_b;
      end else begin
         b_eff_s = i_b;
      end
   end

   assign cin_s = i_sub | i_c0;

   // pre-processing register: per-bit generate/propagate and beat control
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         g_pre_r      <= '0;
         p_pre_r      <= '0;
         p_save_pre_r <= '0;
         ctrl_pre_r   <= '0;
      end else if (advance_s) begin
         g_pre_r          <= i_a & b_eff_s;
         p_pre_r          <= i_a ^ b_eff_s;
         p_save_pre_r     <= i_a ^ b_eff_s;
         ctrl_pre_r.valid <= i_valid;
         ctrl_pre_r.sub   <= i_sub;
         ctrl_pre_r.cin   <= cin_s;
      end
   end

   assign g_lvl_s[0]      = g_pre_r;
   assign p_lvl_s[0]      = p_pre_r;
   assign p_save_lvl_s[0] = p_save_pre_r;
   assign ctrl_lvl_s[0]   = ctrl_pre_r;

   for (genvar k = 1; k <= LOG2W; k++) begin : g_level
      ks_prefix_level #(
         .WIDTH (WIDTH),
         .LEVEL (k)
      ) u_level (
         .clk         (i_clk),
         .rst_n       (i_rst_n),
         .advance     (advance_s),
         .g_prev      (g_lvl_s[k-1]),
         .p_prev      (p_lvl_s[k-1]),
         .p_save_prev (p_save_lvl_s[k-1]),
         .ctrl_prev   (ctrl_lvl_s[k-1]),
         .g           (g_lvl_s[k]),
         .p           (p_lvl_s[k]),
         .p_save      (p_save_lvl_s[k]),
         .ctrl        (ctrl_lvl_s[k])
      );
   end

   assign carry_s = {g_lvl_s[LOG2W][WIDTH-2:0], ctrl_lvl_s[LOG2W].cin};
   assign sum_s   = p_save_lvl_s[LOG2W] ^ carry_s;

   // the MSB group spans bits WIDTH-1..0 only, so the carry-in is folded here
   grey_cell u_cout (
      .g_hi  (g_lvl_s[LOG2W][WIDTH-1]),
      .p_hi  (p_lvl_s[LOG2W][WIDTH-1]),
      .g_lo  (ctrl_lvl_s[LOG2W].cin),
      .g_out (cout_s)
   );

   assign ovf_s = carry_s[WIDTH-1] ^ cout_s;

   // output register; holds its beat while downstream is not ready
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_r <= 1'b0;
         sum_r   <= '0;
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else if (advance_s) begin
         valid_r <= ctrl_lvl_s[LOG2W].valid;
         sum_r   <= sum_s;
         cout_r  <= cout_s;
         ovf_r   <= ovf_s;
      end
   end

   assign o_valid = valid_r;
   assign o_sum   = sum_r;
   assign o_cout  = cout_r;
   assign o_ovf   = ovf_r;

endmodule
